// File: rtl/despachador_ascensores_if.sv
// Signal bundle between the dispatcher, the floor-request FIFO and both elevator units.
interface despachador_ascensores_if;
  logic       fifo_empty;
  logic [1:0] fifo_dout;
  logic       fifo_rd_en;
  logic [1:0] piso_asc_1;
  logic [1:0] piso_asc_2;
  logic       ocupado_asc_1;
  logic       ocupado_asc_2;
  logic [2:0] destino_asc_1;
  logic [2:0] destino_asc_2;
  logic [1:0] asignado;
  logic [7:0] errores;

  modport master (
    output fifo_empty, fifo_dout, piso_asc_1, piso_asc_2, ocupado_asc_1, ocupado_asc_2,
    input  fifo_rd_en, destino_asc_1, destino_asc_2, asignado, errores
  );

  modport slave (
    input  fifo_empty, fifo_dout, piso_asc_1, piso_asc_2, ocupado_asc_1, ocupado_asc_2,
    output fifo_rd_en, destino_asc_1, destino_asc_2, asignado, errores
  );
endinterface

// File: rtl/despachador_ascensores.sv
// Pops floor requests one at a time and hands each to the closer free elevator.
// Optional DESPACHO_ALTERNADO_EN: equal-distance ties alternate between elevators.
module despachador_ascensores #(
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     reset_n,
  despachador_ascensores_if.slave  bus
);

  localparam int unsigned TIMER_W = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned ERR_W   = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    CAPTURE,
    DECIDE,
    ISSUE1,
    ISSUE2
  } state_t;

  state_t               state;
  logic [1:0]           req;
  logic [TIMER_W-1:0]   timer;

  logic [1:0]           dist_1_c;
  logic [1:0]           dist_2_c;
  logic                 pick_2_c;
  logic                 ack_c;
  logic                 timeout_c;

`ifdef DESPACHO_ALTERNADO_EN
  logic                 tie_sel;
  logic                 tie_c;
  assign tie_c = !bus.ocupado_asc_1 && !bus.ocupado_asc_2 && (dist_1_c == dist_2_c);
`endif

  // Elevator choice: a lone free elevator wins, otherwise the nearer one; ties to asc_1 unless alternating.
  always_comb begin
    dist_1_c = (req >= bus.piso_asc_1) ? (req - bus.piso_asc_1) : (bus.piso_asc_1 - req);
    dist_2_c = (req >= bus.piso_asc_2) ? (req - bus.piso_asc_2) : (bus.piso_asc_2 - req);
    pick_2_c = 1'b0;
    if (bus.ocupado_asc_1)
      pick_2_c = 1'b1;
    else if (bus.ocupado_asc_2)
      pick_2_c = 1'b0;
    else if (dist_2_c < dist_1_c)
      pick_2_c = 1'b1;
`ifdef DESPACHO_ALTERNADO_EN
    else if (dist_2_c == dist_1_c)
      pick_2_c = tie_sel;
`endif
  end

  assign ack_c     = (state == ISSUE1) ? bus.ocupado_asc_1 : bus.ocupado_asc_2;
  assign timeout_c = (timer == TIMER_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      req               <= '0;
      timer             <= '0;
      bus.fifo_rd_en    <= 1'b0;
      bus.destino_asc_1 <= '0;
      bus.destino_asc_2 <= '0;
      bus.asignado      <= '0;
      bus.errores       <= '0;
`ifdef DESPACHO_ALTERNADO_EN
      tie_sel           <= 1'b0;
`endif
    end else begin
      bus.fifo_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.fifo_empty) begin
            state          <= POP;
            bus.fifo_rd_en <= 1'b1;
          end
        end
        POP: state <= CAPTURE;
        CAPTURE: begin
          req   <= bus.fifo_dout;
          state <= DECIDE;
        end
        // Both busy: hold the request here; no further pops until it is placed.
        DECIDE: begin
          if (!(bus.ocupado_asc_1 && bus.ocupado_asc_2)) begin
            timer <= '0;
            if (pick_2_c) begin
              state             <= ISSUE2;
              bus.destino_asc_2 <= {1'b1, req};
              bus.asignado      <= 2'b10;
            end else begin
              state             <= ISSUE1;
              bus.destino_asc_1 <= {1'b1, req};
              bus.asignado      <= 2'b01;
            end
`ifdef DESPACHO_ALTERNADO_EN
            if (tie_c)
              tie_sel <= ~tie_sel;
`endif
          end
        end
        // Acknowledge takes priority; on timeout the request is dropped and counted.
        ISSUE1, ISSUE2: begin
          if (ack_c || timeout_c) begin
            state             <= IDLE;
            bus.destino_asc_1 <= '0;
            bus.destino_asc_2 <= '0;
            if (!ack_c && (bus.errores != ERR_MAX))
              bus.errores <= bus.errores + ERR_W'(1);
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
